// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM states, data-op
// encodings and the default wait-state count.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Existing 2-bit data-op encodings; 2'b00 and 2'b01 are not memory ops.
    localparam logic [1:0] kDMEM_OP_STORE = 2'b10;
    localparam logic [1:0] kDMEM_OP_LOAD  = 2'b11;

    localparam int kDMEM_WAIT = 2;

    function automatic logic dmem_is_mem_op(input logic [1:0] op);
        return (op == kDMEM_OP_STORE) || (op == kDMEM_OP_LOAD);
    endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Byte storage for the responder: synchronous write, registered read,
// one port shared between both.
module dmem_array #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          Clk,
    input  logic          WrEn,
    input  logic          RdEn,
    input  logic [AW-1:0] Addr,
    input  logic [DW-1:0] WData,
    output logic [DW-1:0] RData
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];

    // NOTE: storage and read register have no reset; contents survive Reset_n
    // and a reset port here would stop the array mapping onto RAM.
    always_ff @(posedge Clk) begin
        if (WrEn) begin
            r_mem[Addr] <= WData;
        end
        if (RdEn) begin
            RData <= r_mem[Addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, then a
// held response. Optional access counters via `define DMEM_ACCESS_COUNT_EN.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int AW          = 8,
    parameter int DW          = 8,
    parameter int WAIT_CYCLES = kDMEM_WAIT
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          ReqValid,
    output logic          ReqReady,
    input  logic [1:0]    ReqOp,
    input  logic [AW-1:0] ReqAddr,
    input  logic [DW-1:0] ReqWData,
    output logic          RspValid,
    input  logic          RspReady,
    output logic [1:0]    RspOp,
    output logic [DW-1:0] RspRData,
    output logic          RspErr
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    output logic [15:0]   LoadCount,
    output logic [15:0]   StoreCount
`endif
);

    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

    dmem_state_t   r_state;
    logic [3:0]    r_cnt;
    logic [1:0]    r_op;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_rsp_valid;
    logic [1:0]    r_rsp_op;
    logic          r_rsp_err;
    logic          r_rsp_load;

    logic          w_access;
    logic [1:0]    w_acc_op;
    logic [AW-1:0] w_acc_addr;
    logic [DW-1:0] w_acc_wdata;
    logic          w_acc_store;
    logic          w_acc_load;
    logic [DW-1:0] w_rdata;

    // With zero wait states the access happens on the accept edge, so the
    // request is taken straight from the ports instead of the latched copy.
    assign w_acc_op    = (r_state == IDLE) ? ReqOp    : r_op;
    assign w_acc_addr  = (r_state == IDLE) ? ReqAddr  : r_addr;
    assign w_acc_wdata = (r_state == IDLE) ? ReqWData : r_wdata;
    assign w_access    = ((r_state == IDLE) && ReqValid && (LP_WAIT == 4'd0)) ||
                         ((r_state == WAIT) && (r_cnt == 4'd1));
    assign w_acc_store = w_access && (w_acc_op == kDMEM_OP_STORE);
    assign w_acc_load  = w_access && (w_acc_op == kDMEM_OP_LOAD);

    dmem_array #(
        .AW (AW),
        .DW (DW)
    ) u_array (
        .Clk   (Clk),
        .WrEn  (w_acc_store),
        .RdEn  (w_acc_load),
        .Addr  (w_acc_addr),
        .WData (w_acc_wdata),
        .RData (w_rdata)
    );

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_op        <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_op    <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_load  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (ReqValid) begin
                        r_op    <= ReqOp;
                        r_addr  <= ReqAddr;
                        r_wdata <= ReqWData;
                        r_cnt   <= LP_WAIT;
                        r_state <= (LP_WAIT == 4'd0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (RspReady) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_access) begin
                r_rsp_valid <= 1'b1;
                r_rsp_op    <= w_acc_op;
                r_rsp_err   <= !dmem_is_mem_op(w_acc_op);
                r_rsp_load  <= (w_acc_op == kDMEM_OP_LOAD);
            end
        end
    end

    // Read data lives in the array's output register; gate it so stores,
    // illegal ops and reset present zero.
    assign RspRData = r_rsp_load ? w_rdata : '0;
    assign ReqReady = (r_state == IDLE);
    assign RspValid = r_rsp_valid;
    assign RspOp    = r_rsp_op;
    assign RspErr   = r_rsp_err;

`ifdef DMEM_ACCESS_COUNT_EN
    logic [15:0] r_load_cnt;
    logic [15:0] r_store_cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_load_cnt  <= '0;
            r_store_cnt <= '0;
        end else begin
            if (w_acc_load && (r_load_cnt != 16'hFFFF)) begin
                r_load_cnt <= r_load_cnt + 16'd1;
            end
            if (w_acc_store && (r_store_cnt != 16'hFFFF)) begin
                r_store_cnt <= r_store_cnt + 16'd1;
            end
        end
    end

    assign LoadCount  = r_load_cnt;
    assign StoreCount = r_store_cnt;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a WAIT_CYCLES=2 instance driven by a
// vector table, hand sequences and random traffic, plus a WAIT_CYCLES=0 instance.
module tb_dmem_responder;

    localparam int W = 2;

    logic       Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       Reset_n, ReqValid, ReqReady, RspValid, RspReady, RspErr;
    logic [1:0] ReqOp, RspOp;
    logic [7:0] ReqAddr, ReqWData, RspRData;

    logic       b_Reset_n, b_ReqValid, b_ReqReady, b_RspValid, b_RspReady, b_RspErr;
    logic [1:0] b_ReqOp, b_RspOp;
    logic [7:0] b_ReqAddr, b_ReqWData, b_RspRData;

`ifdef DMEM_ACCESS_COUNT_EN
    logic [15:0] LoadCount, StoreCount, b_LoadCount, b_StoreCount;
`endif

    dmem_responder #(.AW(8), .DW(8), .WAIT_CYCLES(W)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqOp(ReqOp), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
        .RspValid(RspValid), .RspReady(RspReady), .RspOp(RspOp),
        .RspRData(RspRData), .RspErr(RspErr)
`ifdef DMEM_ACCESS_COUNT_EN
        , .LoadCount(LoadCount), .StoreCount(StoreCount)
`endif
    );

    dmem_responder #(.AW(8), .DW(8), .WAIT_CYCLES(0)) dut0 (
        .Clk(Clk), .Reset_n(b_Reset_n), .ReqValid(b_ReqValid), .ReqReady(b_ReqReady),
        .ReqOp(b_ReqOp), .ReqAddr(b_ReqAddr), .ReqWData(b_ReqWData),
        .RspValid(b_RspValid), .RspReady(b_RspReady), .RspOp(b_RspOp),
        .RspRData(b_RspRData), .RspErr(b_RspErr)
`ifdef DMEM_ACCESS_COUNT_EN
        , .LoadCount(b_LoadCount), .StoreCount(b_StoreCount)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain byte array plus access tallies.
    logic [7:0] m_mem  [256];
    logic [7:0] m0_mem [256];
    int         m_loads, m_stores;

    typedef struct {
        logic [1:0] op;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic       exp_err;
        int         hold;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One transaction on the WAIT_CYCLES=2 instance; starts and ends at a negedge in IDLE.
    task automatic txn(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wdata,
                       input int hold, input logic [7:0] exp_rd, input logic exp_err);
        int lat;
        check("req_ready_before_accept", ReqReady, 1);
        ReqValid = 1'b1; ReqOp = op; ReqAddr = addr; ReqWData = wdata;
        RspReady = 1'($urandom);
        @(negedge Clk);
        ReqValid = 1'b0; ReqOp = 2'($urandom); ReqAddr = 8'($urandom); ReqWData = 8'($urandom);
        lat = 1;
        while (!RspValid && lat < 64) begin
            RspReady = 1'($urandom);
            @(negedge Clk);
            lat++;
        end
        RspReady = 1'b0;
        check("latency", lat, W + 1);
        check("rsp_op", RspOp, op);
        check("rsp_err", RspErr, exp_err);
        check("rsp_rdata", RspRData, exp_rd);
        for (int i = 0; i < hold; i++) begin
            // A competing request during backpressure must be ignored.
            ReqValid = (i == 1); ReqOp = 2'b10; ReqAddr = 8'h10; ReqWData = 8'hEE;
            @(negedge Clk);
            check("hold_valid", RspValid, 1);
            check("hold_rdata", RspRData, exp_rd);
            check("hold_op", RspOp, op);
            check("hold_req_ready", ReqReady, 0);
        end
        ReqValid = 1'b0;
        RspReady = 1'b1;
        @(negedge Clk);
        RspReady = 1'b0;
        check("post_hs_valid", RspValid, 0);
        check("post_hs_err", RspErr, 0);
        check("post_hs_ready", ReqReady, 1);
        if (op == 2'b10) begin
            m_mem[addr] = wdata;
            m_stores++;
        end else if (op == 2'b11) begin
            m_loads++;
        end
`ifdef DMEM_ACCESS_COUNT_EN
        check("load_count", LoadCount, m_loads);
        check("store_count", StoreCount, m_stores);
`endif
    endtask

    // Model-driven transaction: expected values come from the reference array.
    task automatic txn_model(input logic [1:0] op, input logic [7:0] addr,
                             input logic [7:0] wdata, input int hold);
        logic [7:0] exp_rd;
        exp_rd = (op == 2'b11) ? m_mem[addr] : 8'h00;
        txn(op, addr, wdata, hold, exp_rd, !(op == 2'b10 || op == 2'b11));
    endtask

    // Zero-wait-state instance with RspReady tied high.
    task automatic txn0(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wdata);
        logic [7:0] exp_rd;
        exp_rd = (op == 2'b11) ? m0_mem[addr] : 8'h00;
        check("w0_ready", b_ReqReady, 1);
        b_ReqValid = 1'b1; b_ReqOp = op; b_ReqAddr = addr; b_ReqWData = wdata;
        @(negedge Clk);
        b_ReqValid = 1'b0;
        check("w0_latency_valid", b_RspValid, 1);
        check("w0_rsp_op", b_RspOp, op);
        check("w0_rsp_rdata", b_RspRData, exp_rd);
        @(negedge Clk);
        check("w0_post_hs_valid", b_RspValid, 0);
        if (op == 2'b10) m0_mem[addr] = wdata;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [1:0] op;
        Reset_n = 1'b0; ReqValid = 1'b0; ReqOp = '0; ReqAddr = '0; ReqWData = '0; RspReady = 1'b0;
        b_Reset_n = 1'b0; b_ReqValid = 1'b0; b_ReqOp = '0; b_ReqAddr = '0; b_ReqWData = '0;
        b_RspReady = 1'b1;
        m_loads = 0; m_stores = 0;

        vecs[0] = '{2'b10, 8'h10, 8'hA5, 8'h00, 1'b0, 0};
        vecs[1] = '{2'b11, 8'h10, 8'h00, 8'hA5, 1'b0, 0};
        vecs[2] = '{2'b00, 8'h10, 8'h5A, 8'h00, 1'b1, 0};
        vecs[3] = '{2'b11, 8'h10, 8'h00, 8'hA5, 1'b0, 2};
        vecs[4] = '{2'b01, 8'hFF, 8'h33, 8'h00, 1'b1, 1};
        vecs[5] = '{2'b10, 8'hFF, 8'h3C, 8'h00, 1'b0, 0};
        vecs[6] = '{2'b11, 8'hFF, 8'h00, 8'h3C, 1'b0, 5};
        vecs[7] = '{2'b11, 8'h10, 8'h00, 8'hA5, 1'b0, 0};
        vecs[8] = '{2'b10, 8'h00, 8'h81, 8'h00, 1'b0, 3};
        vecs[9] = '{2'b11, 8'h00, 8'h00, 8'h81, 1'b0, 0};

        repeat (2) @(negedge Clk);
        Reset_n = 1'b1; b_Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            check("idle_req_ready", ReqReady, 1);
            check("idle_rsp_valid", RspValid, 0);
            check("idle_rsp_rdata", RspRData, 0);
            check("idle_rsp_err", RspErr, 0);
        end
`ifdef DMEM_ACCESS_COUNT_EN
        check("reset_load_count", LoadCount, 0);
        check("reset_store_count", StoreCount, 0);
`endif

        for (int i = 0; i < 10; i++) begin
            txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].hold,
                vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Reset during WAIT of a store: the store is discarded.
        txn_model(2'b10, 8'h20, 8'h77, 0);
        txn_model(2'b11, 8'h20, 8'h00, 0);
        ReqValid = 1'b1; ReqOp = 2'b10; ReqAddr = 8'h20; ReqWData = 8'h3C;
        @(negedge Clk);
        ReqValid = 1'b0;
        check("mid_wait_ready", ReqReady, 0);
        #1 Reset_n = 1'b0;
        #1;
        check("rst_wait_ready", ReqReady, 1);
        check("rst_wait_valid", RspValid, 0);
        check("rst_wait_rdata", RspRData, 0);
        check("rst_wait_op", RspOp, 0);
        check("rst_wait_err", RspErr, 0);
        m_loads = 0; m_stores = 0;
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        txn_model(2'b11, 8'h20, 8'h00, 0);

        // Reset during RESP of a store: the write already happened.
        ReqValid = 1'b1; ReqOp = 2'b10; ReqAddr = 8'h21; ReqWData = 8'h5A;
        @(negedge Clk);
        ReqValid = 1'b0;
        lat = 1;
        while (!RspValid && lat < 64) begin
            @(negedge Clk);
            lat++;
        end
        check("resp_rst_latency", lat, W + 1);
        #1 Reset_n = 1'b0;
        #1;
        check("rst_resp_valid", RspValid, 0);
        m_mem[8'h21] = 8'h5A;
        m_loads = 0; m_stores = 0;
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        txn_model(2'b11, 8'h21, 8'h00, 0);

        // Random traffic over a small address window.
        for (int a = 0; a < 16; a++) txn_model(2'b10, 8'(8'h40 + a), 8'($urandom), 0);
        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 9);
            op = (r < 4) ? 2'b10 : (r < 8) ? 2'b11 : 2'($urandom_range(0, 1));
            txn_model(op, 8'(8'h40 + $urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 3));
        end
        txn_model(2'b11, 8'h10, 8'h00, 0);

        // Zero wait states: 2 stores, 3 loads.
        txn0(2'b10, 8'h01, 8'h11);
        txn0(2'b10, 8'h02, 8'h22);
        txn0(2'b11, 8'h01, 8'h00);
        txn0(2'b11, 8'h02, 8'h00);
        txn0(2'b11, 8'h01, 8'h00);
`ifdef DMEM_ACCESS_COUNT_EN
        check("w0_load_count", b_LoadCount, 3);
        check("w0_store_count", b_StoreCount, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the core's LOAD/STORE path.
- Accepts one memory request at a time from the execute stage over a valid/ready handshake.
- Performs the byte access after a programmable number of wait states, then returns a response over a second valid/ready handshake.
- Owns the data storage array; single outstanding request, so read-after-write ordering is inherent.

Parameters:
- AW, 8, address width; storage holds 2**AW bytes.
- DW, 8, data width in bits.
- WAIT_CYCLES, 2, wait states between request acceptance and memory access; legal range 0..15.

Ports:
- Clk  input  1  system clock, all state on rising edge
- Reset_n  input  1  asynchronous active-low reset
- ReqValid  input  1  request present
- ReqReady  output  1  responder can accept a request
- ReqOp  input  2  2'b10 store, 2'b11 load, others illegal
- ReqAddr  input  AW  byte address
- ReqWData  input  DW  store data
- RspValid  output  1  response present
- RspReady  input  1  core accepts response
- RspOp  output  2  echo of accepted ReqOp
- RspRData  output  DW  load data; 0 for store or illegal op
- RspErr  output  1  accepted op was not a memory op

Behaviour:
- States: IDLE, WAIT, RESP; 2-bit state register with asynchronous reset.
- Reset (Reset_n low, takes effect immediately):
  - state=IDLE, wait counter=0, RspValid=0, RspOp=0, RspRData=0, RspErr=0.
  - ReqReady=1, since it is decoded as state==IDLE.
  - Storage contents are not reset.
- Accept: ReqValid && ReqReady at a rising edge. Latch op, addr, wdata; load counter with WAIT_CYCLES.
  - WAIT_CYCLES>0: IDLE->WAIT.
  - WAIT_CYCLES==0: IDLE->RESP directly, performing the access on that edge.
- WAIT:
  - Counter decrements each cycle.
  - On the edge where counter==1: perform the access and go to RESP.
- Access, single edge, on entry to RESP:
  - Store: mem[addr]<=wdata; RspRData<=0.
  - Load: RspRData<=mem[addr].
  - Illegal op (2'b00/2'b01): no storage access; RspRData<=0; RspErr<=1.
  - RspOp<=latched op in all cases.
- RESP:
  - RspValid=1; RspOp/RspRData/RspErr held stable until the handshake.
  - On RspValid && RspReady: ->IDLE, RspValid=0 next cycle, RspErr cleared.
- Latency: acceptance edge to first cycle of RspValid is WAIT_CYCLES+1 cycles.
- Throughput: one request per WAIT_CYCLES+2 cycles minimum. No request/response overlap; ReqReady=0 in WAIT and RESP.
- ReqValid while not ready: ignored; the request must be held by the core.
- RspReady asserted outside RESP: ignored.
- Reset mid-operation:
  - In WAIT: the pending store is discarded with no write.
  - In RESP: the write has already occurred; the response is dropped.
- Address: exactly AW bits index the array; no out-of-range case.

Optional Feature:
- Macro: DMEM_ACCESS_COUNT_EN.
- Defined:
  - Adds output ports LoadCount[15:0] and StoreCount[15:0], both reset to 0.
  - Each counter increments at the access edge of its op type and saturates at 16'hFFFF.
  - Illegal ops count in neither.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared definitions package:
  - State enum dmem_state_t {IDLE, WAIT, RESP}.
  - Store/load opcode constants, reusing the existing 2-bit data-op encodings.
  - Default-latency constant kDMEM_WAIT.
- Sub-module dmem_array:
  - Synchronous write, registered read.
  - Ports Clk, WrEn, RdEn, Addr, WData, RData.
  - Instantiated once.
- FSM, counter and handshake logic stay in dmem_responder.

Test Plan:
- Reset release, no requests -> ReqReady=1, RspValid=0, RspRData=0 every cycle.
- Store 8'hA5 at addr 8'h10, then load addr 8'h10, WAIT_CYCLES=2, RspReady tied 1:
  - RspValid rises exactly 3 cycles after each accept.
  - Load returns RspRData=8'hA5, RspErr=0, RspOp=2'b11.
- ReqOp=2'b00 with addr 8'h10 -> RspErr=1, RspRData=0, mem[8'h10] still 8'hA5 on a following load.
- Response backpressure, RspReady held 0 for 5 cycles:
  - RspValid and RspRData stable throughout; ReqReady=0 throughout.
  - A second ReqValid pulse is not accepted.
  - Returns to IDLE one cycle after RspReady=1.
- Reset_n pulsed low during WAIT of a store of 8'h3C to 8'h20 -> outputs at reset values immediately; a later load of 8'h20 returns the prior contents, not 8'h3C.
- WAIT_CYCLES=0 build: load latency 1 cycle; with DMEM_ACCESS_COUNT_EN, 3 loads + 2 stores -> LoadCount=3, StoreCount=2.
